multicycle_control: RTL

//  Main controller of the multicycle datapath, sitting directly upstream of the ALU.

---
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main controller of the multicycle datapath. Sequences every instruction
//   through FETCH / DECODE / EXEC / MEM / WB states and decodes all datapath
//   enables, mux selects and the 3-bit ALUControl from the current state
//   (plus Op/Funct/Zero where they matter).
//
// Ports
//   clk        : clock, all state changes on rising edge
//   reset      : asynchronous active-high, forces FETCH and gates all enables
//   Op, Funct  : instruction[31:26] and instruction[5:0] from the IR
//   Zero       : ALU zero flag, resolves beq
//   IorD, MemWrite, IRWrite, PCEn, PCSrc, RegDst, MemtoReg, RegWrite,
//   ALUSrcA, ALUSrcB, ALUControl : datapath controls
//   IllegalOp  : one-cycle flag in DECODE for an unsupported instruction
//   State      : current state, zero-extended to STATE_W (debug)
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCEn,
    output logic               PCSrc,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_BEQ = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10
    } state_t;

    state_t state_q, state_d;

    // Raw enables before reset gating
    logic pc_write, branch, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;

    function automatic logic funct_legal(input logic [5:0] f);
        case (f)
            F_ADD, F_AND, F_XOR, F_OR: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            F_AND:   return ALU_AND;
            F_XOR:   return ALU_XOR;
            F_OR:    return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        branch        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        IorD          = 1'b0;
        PCSrc         = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                ALUSrcB      = 2'b01;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut regardless of opcode
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_RTYPE: begin
                        if (funct_legal(Funct)) begin
                            state_d = S_EXECUTE;
                        end else begin
                            illegal_raw = 1'b1;
                        end
                    end
                    default: illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu(Funct);
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_BEQ;
                PCSrc      = 1'b1;
                branch     = 1'b1;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            default: begin
                // Unreachable encodings: recover to FETCH with everything off
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset gates the enables combinationally so an abandoned instruction
    // cannot write anything in the cycle reset rises.
    assign MemWrite  = mem_write_raw & ~reset;
    assign IRWrite   = ir_write_raw  & ~reset;
    assign RegWrite  = reg_write_raw & ~reset;
    assign IllegalOp = illegal_raw   & ~reset;
    assign PCEn      = (pc_write | (branch & Zero)) & ~reset;

    assign State = STATE_W'(state_q);

endmodule
